npu_wb_mailbox: RTL and testbench
=================================

NPU_WB_MAILBOX -- requirements
Module: npu_wb_mailbox

Interface
REQ-001 SHALL have parameter NCH, default 2, meaning the number of NPU command/result channels (1..4).
REQ-002 SHALL have parameter DEPTH, default 8, meaning per-channel FIFO depth (power of 2, 2..16).
REQ-003 SHALL have parameter BASE_ADR, default 32'h3000_0000, meaning the Wishbone window base, matched on adr[31:8].
REQ-004 SHALL have port wb_clk_i, input, 1, the single clock for all logic.
REQ-005 SHALL have port wb_rst_ni, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports wbs_cyc_i, wbs_stb_i and wbs_we_i, each input, 1, Wishbone classic strobes.
REQ-007 SHALL have ports wbs_sel_i, input, 4, byte selects; and wbs_adr_i, input, 32, byte address.
REQ-008 SHALL have ports wbs_dat_i, input, 32, write data; wbs_dat_o, output, 32, read data; and wbs_ack_o, output, 1, acknowledge.
REQ-009 SHALL have ports cmd_valid_o, output, NCH; cmd_data_o, output, 32*NCH; and cmd_ready_i, input, NCH, forming the per-channel command stream to the NPU.
REQ-010 SHALL have ports res_valid_i, input, NCH; res_data_i, input, 32*NCH; and res_ready_o, output, NCH, forming the per-channel result stream from the NPU.
REQ-011 SHALL have port irq_o, output, NCH, per-channel interrupt.

Function
REQ-012 SHALL decode a hit as cyc&stb&(adr[31:8]==BASE_ADR[31:8]); channel c occupies offsets c*0x10: +0 CMD (W), +4 RES (R), +8 STATUS (R, write-1-clear sticky bits), +C IRQ_EN (RW).
REQ-013 SHALL assert wbs_ack_o for exactly one cycle, the cycle after a hit, and SHALL hold it low for the next cycle even if stb stays high (two-cycle minimum per access).
REQ-014 SHALL return 0 in wbs_dat_o for misses, unused offsets and channels >= NCH, and SHALL still ack hits to such offsets.
REQ-015 SHALL push wbs_dat_i into CMD FIFO c on an acked CMD write only when sel==4'hF and count<DEPTH; sel!=4'hF sets STATUS.ERR and pushes nothing; a full FIFO sets STATUS.OVF and drops the data.
REQ-016 SHALL pop RES FIFO c on an acked RES read and return its head; when empty it SHALL return 0 and set STATUS.UDF.
REQ-017 STATUS SHALL read as {count_res[20:16], count_cmd[12:8], 5'b0, ERR[2], UDF[1], OVF[0]}, with counts 0..DEPTH.
REQ-018 cmd_valid_o[c] SHALL be high when CMD FIFO c is non-empty, with cmd_data_o[c] equal to the head (registered, zero-latency show-ahead); a pop occurs on valid&ready.
REQ-019 res_ready_o[c] SHALL equal (RES count<DEPTH), and a push occurs on valid&ready.
REQ-020 Simultaneous push and pop on one FIFO SHALL leave the count unchanged; acceptance SHALL use the pre-cycle count (no pass-through when full or empty).
REQ-021 Pointers SHALL wrap modulo DEPTH; the count SHALL use log2(DEPTH)+1 bits.
REQ-022 Writing 1 to a STATUS bit SHALL clear it; if a set event and a clear happen in the same cycle, set SHALL win.

Reset
REQ-023 On wb_rst_ni low: wbs_ack_o=0, wbs_dat_o=0, cmd_valid_o=0, res_ready_o=0, irq_o=0, all pointers, counts, sticky bits and IRQ_EN =0, asynchronously.
REQ-024 Reset asserted mid-transfer SHALL abort it with no ack; release SHALL be synchronised to wb_clk_i before FIFO state advances.
REQ-025 res_ready_o SHALL go high the first cycle after reset release.

Configuration
REQ-026 With NPU_MBOX_IRQ_EN defined, irq_o[c] SHALL be registered as (IRQ_EN[0]&RES non-empty) | (IRQ_EN[1]&(OVF|UDF|ERR)).
REQ-027 Without NPU_MBOX_IRQ_EN, irq_o SHALL be constant 0, IRQ_EN SHALL read 0 and writes to it SHALL be ignored.

Verification
REQ-028 Write 0xA5A5_0001 to ch0 CMD, sel=F -> ack 1 cycle later; cmd_valid_o[0]=1, data 0xA5A5_0001; ready=1 -> valid drops next cycle.
REQ-029 With cmd_ready_i=0, perform 9 writes to ch1 CMD (DEPTH=8) -> STATUS ch1 = count_cmd 8, OVF=1; write 1 to STATUS bit 0 -> OVF=0.
REQ-030 Read ch0 RES when empty -> dat 0, UDF=1; push 0x1234 on res_* then read -> 0x1234, count_res 0.
REQ-031 Write to CMD with sel=4'h3 -> no push, ERR=1; access to adr BASE+0x40 (NCH=2) -> ack, dat 0.
REQ-032 With NPU_MBOX_IRQ_EN, set IRQ_EN=1 and push a result -> irq_o[0]=1 one cycle later; pop it -> irq_o[0]=0.
REQ-033 Assert wb_rst_ni low during a stb with 3 queued commands -> no ack, cmd_valid_o=0 immediately, counts 0 after release.

Source files
------------

// File: rtl/npu_wb_mailbox.sv
// Wishbone-slave mailbox: per-channel CMD FIFOs toward the NPU, RES FIFOs back, sticky error status.
// Optional per-channel interrupt logic is compiled in with `define NPU_MBOX_IRQ_EN.
module npu_wb_mailbox #(
  parameter int          NCH      = 2,
  parameter int          DEPTH    = 8,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic [31:0]       wbs_dat_o,
  output logic              wbs_ack_o,
  output logic [NCH-1:0]    cmd_valid_o,
  output logic [32*NCH-1:0] cmd_data_o,
  input  logic [NCH-1:0]    cmd_ready_i,
  input  logic [NCH-1:0]    res_valid_i,
  input  logic [32*NCH-1:0] res_data_i,
  output logic [NCH-1:0]    res_ready_o,
  output logic [NCH-1:0]    irq_o
);

  localparam int            AW   = $clog2(DEPTH);
  localparam int            CW   = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    REG_CMD    = 2'd0,
    REG_RES    = 2'd1,
    REG_STATUS = 2'd2,
    REG_IRQ_EN = 2'd3
  } reg_e;

  // sticky bit positions: [0] OVF, [1] UDF, [2] ERR
  logic                    run_q, run_d;
  logic                    ack_q, ack_d;
  logic [31:0]             dat_q, dat_d;
  logic [NCH-1:0][AW-1:0]  cmd_wptr_q, cmd_wptr_d, cmd_rptr_q, cmd_rptr_d;
  logic [NCH-1:0][AW-1:0]  res_wptr_q, res_wptr_d, res_rptr_q, res_rptr_d;
  logic [NCH-1:0][CW-1:0]  cmd_cnt_q, cmd_cnt_d, res_cnt_q, res_cnt_d;
  logic [NCH-1:0][2:0]     sticky_q, sticky_d;
  logic [31:0]             cmd_mem_q [NCH][DEPTH];
  logic [31:0]             res_mem_q [NCH][DEPTH];

  logic [NCH-1:0]          cmd_push, cmd_pop, res_push, res_pop;
  logic [NCH-1:0][2:0]     sts_set, sts_clr;
  logic                    hit, acc;
  logic [3:0]              chan;
  reg_e                    reg_sel;
  logic [31:0]             rdata;
  logic                    unused_adr;

`ifdef NPU_MBOX_IRQ_EN
  logic [NCH-1:0][1:0]     irq_en_q, irq_en_d;
  logic [NCH-1:0]          irq_q, irq_d;
`endif

  assign chan       = wbs_adr_i[7:4];
  assign reg_sel    = reg_e'(wbs_adr_i[3:2]);
  assign unused_adr = ^wbs_adr_i[1:0];
  assign hit        = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADR[31:8]);
  // An access is performed only in the cycle that raises ack; the following cycle is a forced gap.
  assign acc        = hit & ~ack_q & run_q;

  // Register decode, FIFO handshakes and read-data mux.
  always_comb begin
    cmd_push = '0;
    cmd_pop  = '0;
    res_push = '0;
    res_pop  = '0;
    sts_set  = '0;
    sts_clr  = '0;
    rdata    = '0;
    for (int c = 0; c < NCH; c++) begin
      cmd_pop[c]  = (cmd_cnt_q[c] != '0) & cmd_ready_i[c];
      res_push[c] = res_valid_i[c] & res_ready_o[c];
      if (acc && int'(chan) == c) begin
        case (reg_sel)
          REG_CMD: if (wbs_we_i) begin
            if (wbs_sel_i != 4'hF)       sts_set[c][2] = 1'b1;
            else if (cmd_cnt_q[c] == FULL) sts_set[c][0] = 1'b1;
            else                         cmd_push[c]   = 1'b1;
          end
          REG_RES: if (!wbs_we_i) begin
            if (res_cnt_q[c] == '0) sts_set[c][1] = 1'b1;
            else begin
              res_pop[c] = 1'b1;
              rdata      = res_mem_q[c][res_rptr_q[c]];
            end
          end
          REG_STATUS: begin
            if (wbs_we_i) sts_clr[c] = wbs_dat_i[2:0];
            else rdata = {11'b0, 5'(res_cnt_q[c]), 3'b0, 5'(cmd_cnt_q[c]), 5'b0, sticky_q[c]};
          end
          REG_IRQ_EN: begin
`ifdef NPU_MBOX_IRQ_EN
            if (!wbs_we_i) rdata = {30'b0, irq_en_q[c]};
`endif
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    run_d = 1'b1;
    ack_d = acc;
    dat_d = (acc && !wbs_we_i) ? rdata : '0;
    for (int c = 0; c < NCH; c++) begin
      cmd_wptr_d[c] = cmd_wptr_q[c] + AW'(cmd_push[c]);
      cmd_rptr_d[c] = cmd_rptr_q[c] + AW'(cmd_pop[c]);
      cmd_cnt_d[c]  = cmd_cnt_q[c] + CW'(cmd_push[c]) - CW'(cmd_pop[c]);
      res_wptr_d[c] = res_wptr_q[c] + AW'(res_push[c]);
      res_rptr_d[c] = res_rptr_q[c] + AW'(res_pop[c]);
      res_cnt_d[c]  = res_cnt_q[c] + CW'(res_push[c]) - CW'(res_pop[c]);
      // Set is OR-ed after the clear mask so a coincident set event wins.
      sticky_d[c]   = (sticky_q[c] & ~sts_clr[c]) | sts_set[c];
    end
  end

  // run_q is the clock-synchronised reset release; nothing advances until it is high.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      run_q      <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      cmd_wptr_q <= '0;
      cmd_rptr_q <= '0;
      cmd_cnt_q  <= '0;
      res_wptr_q <= '0;
      res_rptr_q <= '0;
      res_cnt_q  <= '0;
      sticky_q   <= '0;
    end else begin
      run_q      <= run_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      cmd_wptr_q <= cmd_wptr_d;
      cmd_rptr_q <= cmd_rptr_d;
      cmd_cnt_q  <= cmd_cnt_d;
      res_wptr_q <= res_wptr_d;
      res_rptr_q <= res_rptr_d;
      res_cnt_q  <= res_cnt_d;
      sticky_q   <= sticky_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; counts gate every read, so stale words are never visible.
  always_ff @(posedge wb_clk_i) begin
    for (int c = 0; c < NCH; c++) begin
      if (cmd_push[c]) cmd_mem_q[c][cmd_wptr_q[c]] <= wbs_dat_i;
      if (res_push[c]) res_mem_q[c][res_wptr_q[c]] <= res_data_i[c*32 +: 32];
    end
  end

  always_comb begin
    cmd_valid_o = '0;
    cmd_data_o  = '0;
    res_ready_o = '0;
    for (int c = 0; c < NCH; c++) begin
      cmd_valid_o[c]          = cmd_cnt_q[c] != '0;
      cmd_data_o[c*32 +: 32]  = cmd_mem_q[c][cmd_rptr_q[c]];
      res_ready_o[c]          = run_q & (res_cnt_q[c] < FULL);
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

`ifdef NPU_MBOX_IRQ_EN
  always_comb begin
    irq_en_d = irq_en_q;
    irq_d    = '0;
    for (int c = 0; c < NCH; c++) begin
      if (acc && wbs_we_i && reg_sel == REG_IRQ_EN && int'(chan) == c)
        irq_en_d[c] = wbs_dat_i[1:0];
      irq_d[c] = (irq_en_q[c][0] & (res_cnt_q[c] != '0)) | (irq_en_q[c][1] & (|sticky_q[c]));
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      irq_en_q <= '0;
      irq_q    <= '0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = '0;
`endif

endmodule

// File: tb/tb_npu_wb_mailbox.sv
// Self-checking bench for npu_wb_mailbox: directed scenarios plus randomized traffic against
// a queue-based reference model of the mailbox registers.
module tb_npu_wb_mailbox;

  localparam int          NCH   = 2;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h3000_0000;

  logic              clk, rst_n;
  logic              cyc, stb, we;
  logic [3:0]        sel;
  logic [31:0]       adr, dat_i, dat_o;
  logic              ack;
  logic [NCH-1:0]    cmd_valid, cmd_ready, res_valid, res_ready, irq;
  logic [32*NCH-1:0] cmd_data, res_data;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [31:0] cmdq [NCH][$];
  logic [31:0] resq [NCH][$];
  logic        ovf [NCH];
  logic        udf [NCH];
  logic        err [NCH];
  logic [1:0]  ien [NCH];

  npu_wb_mailbox #(.NCH(NCH), .DEPTH(DEPTH), .BASE_ADR(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_dat_o(dat_o), .wbs_ack_o(ack),
    .cmd_valid_o(cmd_valid), .cmd_data_o(cmd_data), .cmd_ready_i(cmd_ready),
    .res_valid_i(res_valid), .res_data_i(res_data), .res_ready_o(res_ready),
    .irq_o(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ra(input int c, input int r);
    return BASE + 32'(c * 16 + r * 4);
  endfunction

  function automatic logic [31:0] model_status(input int c);
    return (32'(resq[c].size()) << 16) | (32'(cmdq[c].size()) << 8) |
           {29'b0, err[c], udf[c], ovf[c]};
  endfunction

  function automatic logic [31:0] model_irq();
    logic [31:0] v;
    v = '0;
`ifdef NPU_MBOX_IRQ_EN
    for (int c = 0; c < NCH; c++)
      v[c] = (ien[c][0] && resq[c].size() > 0) || (ien[c][1] && (ovf[c] || udf[c] || err[c]));
`endif
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      cmdq[c].delete();
      resq[c].delete();
      ovf[c] = 1'b0;
      udf[c] = 1'b0;
      err[c] = 1'b0;
      ien[c] = 2'b00;
    end
  endtask

  task automatic model_wb(input logic w, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, output logic [31:0] exp);
    int c, r;
    c   = int'(a[7:4]);
    r   = int'(a[3:2]);
    exp = '0;
    if (a[31:8] != BASE[31:8] || c >= NCH) return;
    if (w) begin
      if (r == 0) begin
        if (s != 4'hF) err[c] = 1'b1;
        else if (cmdq[c].size() >= DEPTH) ovf[c] = 1'b1;
        else cmdq[c].push_back(d);
      end else if (r == 2) begin
        if (d[0]) ovf[c] = 1'b0;
        if (d[1]) udf[c] = 1'b0;
        if (d[2]) err[c] = 1'b0;
      end else if (r == 3) begin
`ifdef NPU_MBOX_IRQ_EN
        ien[c] = d[1:0];
`endif
      end
    end else begin
      if (r == 1) begin
        if (resq[c].size() == 0) udf[c] = 1'b1;
        else exp = resq[c].pop_front();
      end else if (r == 2) begin
        exp = model_status(c);
      end else if (r == 3) begin
`ifdef NPU_MBOX_IRQ_EN
        exp = {30'b0, ien[c]};
`endif
      end
    end
  endtask

  // One Wishbone access starting from an idle bus; ends after one idle cycle.
  task automatic wb(input logic w, input logic [31:0] a, input logic [3:0] s,
                    input logic [31:0] d, input string tag);
    int          n;
    logic [31:0] rd, exp;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_i = d;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack && n < 8);
    rd  = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check({tag, "_ack_lat"}, n, 1);
    @(posedge clk); #1;
    check({tag, "_ack_pulse"}, {31'b0, ack}, 0);
    model_wb(w, a, s, d, exp);
    if (!w) check(tag, rd, exp);
  endtask

  task automatic npu_drain(input int c);
    cmd_ready[c] = 1'b1;
    check("cmd_valid_pre", {31'b0, cmd_valid[c]}, {31'b0, cmdq[c].size() > 0});
    if (cmdq[c].size() > 0) check("cmd_data", cmd_data[c*32 +: 32], cmdq[c][0]);
    @(posedge clk); #1;
    cmd_ready[c] = 1'b0;
    if (cmdq[c].size() > 0) void'(cmdq[c].pop_front());
    check("cmd_valid_post", {31'b0, cmd_valid[c]}, {31'b0, cmdq[c].size() > 0});
  endtask

  task automatic npu_push(input int c, input logic [31:0] d);
    res_valid[c]           = 1'b1;
    res_data[c*32 +: 32]   = d;
    check("res_ready", {31'b0, res_ready[c]}, {31'b0, resq[c].size() < DEPTH});
    @(posedge clk); #1;
    res_valid[c] = 1'b0;
    if (resq[c].size() < DEPTH) resq[c].push_back(d);
  endtask

  task automatic check_irq(input string tag);
    @(posedge clk); #1;
    check(tag, {30'b0, irq}, model_irq());
  endtask

  initial begin
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat_i = '0;
    cmd_ready = '0; res_valid = '0; res_data = '0;
    model_reset();
    #1;
    check("rst_ack", {31'b0, ack}, 0);
    check("rst_dat", dat_o, 0);
    check("rst_cmd_valid", {30'b0, cmd_valid}, 0);
    check("rst_res_ready", {30'b0, res_ready}, 0);
    check("rst_irq", {30'b0, irq}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("res_ready_after_release", {30'b0, res_ready}, 32'h3);

    // single command write and NPU consumption
    wb(1'b1, ra(0, 0), 4'hF, 32'hA5A5_0001, "cmd0_wr");
    npu_drain(0);

    // stb held high: ack, forced gap, ack again
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = ra(0, 2); sel = 4'hF;
    @(posedge clk); #1;
    check("hold_ack1", {31'b0, ack}, 1);
    check("hold_dat1", dat_o, model_status(0));
    @(posedge clk); #1;
    check("hold_gap", {31'b0, ack}, 0);
    @(posedge clk); #1;
    check("hold_ack2", {31'b0, ack}, 1);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;

    // CMD overflow on channel 1, then write-1-clear of OVF
    for (int i = 0; i < DEPTH + 1; i++) wb(1'b1, ra(1, 0), 4'hF, $urandom, "cmd1_fill");
    wb(1'b0, ra(1, 2), 4'hF, 0, "sts1_full");
    check("sts1_full_const", model_status(1), 32'h0000_0801);
    wb(1'b1, ra(1, 2), 4'hF, 32'h1, "sts1_clr");
    wb(1'b0, ra(1, 2), 4'hF, 0, "sts1_after_clr");

    // RES underflow, then a real result
    wb(1'b0, ra(0, 1), 4'hF, 0, "res0_empty");
    wb(1'b0, ra(0, 2), 4'hF, 0, "sts0_udf");
    npu_push(0, 32'h0000_1234);
    wb(1'b0, ra(0, 1), 4'hF, 0, "res0_pop");
    wb(1'b0, ra(0, 2), 4'hF, 0, "sts0_after_pop");
    wb(1'b1, ra(0, 2), 4'hF, 32'h7, "sts0_clr_all");

    // partial byte select, unmapped channel, unused offset, address miss
    wb(1'b1, ra(0, 0), 4'h3, 32'hDEAD_BEEF, "cmd_sel3");
    wb(1'b0, ra(0, 2), 4'hF, 0, "sts0_err");
    wb(1'b0, BASE + 32'h40, 4'hF, 0, "unmapped_rd");
    wb(1'b1, BASE + 32'h40, 4'hF, 32'h1, "unmapped_wr");
    wb(1'b0, ra(0, 0), 4'hF, 0, "cmd_offset_rd");
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h100;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("miss_noack", {31'b0, ack}, 0);
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    wb(1'b1, ra(0, 2), 4'hF, 32'h7, "sts0_clr_err");

    // interrupt enable and result-pending interrupt
    wb(1'b1, ra(0, 3), 4'hF, 32'h1, "ien0_wr");
    wb(1'b0, ra(0, 3), 4'hF, 0, "ien0_rd");
    npu_push(0, $urandom);
    check_irq("irq_res_pending");
    wb(1'b0, ra(0, 1), 4'hF, 0, "res0_pop_irq");
    check_irq("irq_res_drained");
    wb(1'b1, ra(0, 3), 4'hF, 32'h0, "ien0_off");

    // RES FIFO full boundary on channel 1
    for (int i = 0; i < DEPTH + 1; i++) npu_push(1, $urandom);
    check("res1_ready_full", {31'b0, res_ready[1]}, 0);
    wb(1'b0, ra(1, 2), 4'hF, 0, "sts1_res_full");
    for (int i = 0; i < DEPTH; i++) wb(1'b0, ra(1, 1), 4'hF, 0, "res1_drain");
    for (int i = 0; i < DEPTH; i++) npu_drain(1);
    wb(1'b1, ra(1, 2), 4'hF, 32'h7, "sts1_clr_all");

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      int c, cw, op;
      op = int'($urandom_range(0, 9));
      c  = int'($urandom_range(0, NCH - 1));
      cw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(NCH, 3)) : c;
      case (op)
        0, 1: wb(1'b1, ra(cw, 0), ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'hF,
                 $urandom, "rnd_cmd_wr");
        2:    npu_drain(c);
        3, 4: npu_push(c, $urandom);
        5, 6: wb(1'b0, ra(cw, 1), 4'hF, 0, "rnd_res_rd");
        7:    wb(1'b0, ra(cw, 2), 4'hF, 0, "rnd_sts_rd");
        8:    wb(1'b1, ra(cw, 2), 4'hF, 32'($urandom_range(0, 7)), "rnd_sts_clr");
        default: begin
          if ($urandom_range(0, 1) == 0)
            wb(1'b1, ra(cw, 3), 4'hF, 32'($urandom_range(0, 3)), "rnd_ien_wr");
          else
            wb(1'b0, ra(cw, 3), 4'hF, 0, "rnd_ien_rd");
        end
      endcase
      check_irq("rnd_irq");
    end

    // reset asserted in the middle of an access with queued commands
    for (int i = 0; i < 3; i++) wb(1'b1, ra(0, 0), 4'hF, $urandom, "pre_rst_cmd");
    check("pre_rst_valid", {31'b0, cmd_valid[0]}, 1);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = ra(0, 0); sel = 4'hF; dat_i = 32'hCAFE_0000;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ack", {31'b0, ack}, 0);
    check("midrst_cmd_valid", {30'b0, cmd_valid}, 0);
    @(posedge clk); #1;
    check("midrst_ack_hold", {31'b0, ack}, 0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    wb(1'b0, ra(0, 2), 4'hF, 0, "post_rst_sts0");
    wb(1'b0, ra(1, 2), 4'hF, 0, "post_rst_sts1");
    check("post_rst_cmd_valid", {30'b0, cmd_valid}, 0);
    check("post_rst_res_ready", {30'b0, res_ready}, 32'h3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
